// File: rtl/sram_adapter_pkg.sv
// Shared types and default sizing for the SRAM request/response adapter.
// Request/response structs are sized for the default widths.
package sram_adapter_pkg;

    typedef enum logic {
        READ  = 1'b0,
        WRITE = 1'b1
    } req_type_e;

    localparam int unsigned DEFAULT_ADDR_NBITS = 10;
    localparam int unsigned DEFAULT_DATA_NBITS = 32;
    localparam int unsigned DEFAULT_RESP_DEPTH = 2;

    typedef struct packed {
        req_type_e                     rtype;
        logic [DEFAULT_ADDR_NBITS-1:0] addr;
        logic [DEFAULT_DATA_NBITS-1:0] data;
    } req_t;

    typedef struct packed {
        req_type_e                     rtype;
        logic [DEFAULT_DATA_NBITS-1:0] data;
    } resp_t;

    // Access issued last cycle whose SRAM result is due this cycle.
    typedef struct packed {
        logic      valid;
        req_type_e rtype;
    } pending_t;

endpackage

// File: rtl/sram_resp_queue.sv
// Small circular FIFO holding responses that could not be delivered at once.
// Pointers wrap modulo DEPTH, so DEPTH need not be a power of two.
module sram_resp_queue #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 33
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [WIDTH-1:0]           enq_data,
    output logic                       deq_val,
    input  logic                       deq_rdy,
    output logic [WIDTH-1:0]           deq_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_NBITS = $clog2(DEPTH);
    localparam int unsigned CNT_NBITS = $clog2(DEPTH + 1);

    logic [WIDTH-1:0]     mem [DEPTH];
    logic [PTR_NBITS-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_NBITS-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_NBITS-1:0] count_q, count_d;
    logic                 enq_fire, deq_fire;

    function automatic logic [PTR_NBITS-1:0] ptr_inc(input logic [PTR_NBITS-1:0] p);
        return (p == PTR_NBITS'(DEPTH - 1)) ? '0 : p + PTR_NBITS'(1);
    endfunction

    assign enq_rdy  = count_q < CNT_NBITS'(DEPTH);
    assign deq_val  = count_q != '0;
    assign deq_data = mem[rd_ptr_q];
    assign count    = count_q;
    assign enq_fire = enq_val & enq_rdy;
    assign deq_fire = deq_val & deq_rdy;

    always_comb begin
        wr_ptr_d = enq_fire ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = deq_fire ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        count_d  = count_q;
        if (enq_fire && !deq_fire) begin
            count_d = count_q + CNT_NBITS'(1);
        end else if (!enq_fire && deq_fire) begin
            count_d = count_q - CNT_NBITS'(1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq_fire) begin
            mem[wr_ptr_q] <= enq_data;
        end
    end

endmodule

// File: rtl/sram_req_adapter.sv
// Val/rdy request port to single-port SRAM pins, with ordered responses for
// both reads and writes and a bypass path that gives 1-cycle read latency.
module sram_req_adapter
    import sram_adapter_pkg::*;
#(
    parameter int unsigned ADDR_NBITS = DEFAULT_ADDR_NBITS,
    parameter int unsigned DATA_NBITS = DEFAULT_DATA_NBITS,
    parameter int unsigned RESP_DEPTH = DEFAULT_RESP_DEPTH
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_val,
    output logic                  req_rdy,
    input  logic                  req_type,
    input  logic [ADDR_NBITS-1:0] req_addr,
    input  logic [DATA_NBITS-1:0] req_data,
    output logic                  resp_val,
    input  logic                  resp_rdy,
    output logic                  resp_type,
    output logic [DATA_NBITS-1:0] resp_data,
    output logic [ADDR_NBITS-1:0] A1,
    output logic                  CE1,
    output logic                  CSB1,
    output logic                  WEB1,
    output logic                  OEB1,
    output logic [DATA_NBITS-1:0] I1,
    input  logic [DATA_NBITS-1:0] O1
);

    localparam int unsigned CNT_NBITS  = $clog2(RESP_DEPTH + 1);
    localparam int unsigned RESP_NBITS = DATA_NBITS + 1;

    pending_t              pend_q, pend_d;
    logic                  fire;
    logic [CNT_NBITS-1:0]  q_count;
    logic [CNT_NBITS:0]    occupancy;
    logic [DATA_NBITS-1:0] pend_data;
    logic [RESP_NBITS-1:0] pend_resp, q_head, resp_sel;
    logic                  q_enq_val, q_deq_val, q_deq_rdy, resp_val_raw;
    // Room is reserved by req_rdy before an access issues, so enq never stalls.
    logic                  unused_enq_rdy;

    // Registers only: keeps resp_rdy out of the req_rdy cone.
    assign occupancy = {1'b0, q_count} + {{CNT_NBITS{1'b0}}, pend_q.valid};
    assign req_rdy   = reset & (occupancy < (CNT_NBITS + 1)'(RESP_DEPTH));
    assign fire      = req_val & req_rdy;

    assign CE1  = 1'b1;
    assign CSB1 = ~fire;
    assign WEB1 = fire ? ~req_type : 1'b1;
    assign A1   = fire ? req_addr : '0;
    assign I1   = fire ? req_data : '0;
    assign OEB1 = ~(reset & pend_q.valid & (pend_q.rtype == READ));

    assign pend_d.valid = fire;
    assign pend_d.rtype = req_type_e'(req_type);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pend_q <= '{valid: 1'b0, rtype: READ};
        end else begin
            pend_q <= pend_d;
        end
    end

    assign pend_data = (pend_q.rtype == WRITE) ? '0 : O1;
    assign pend_resp = {pend_q.rtype, pend_data};

    always_comb begin
        resp_sel     = pend_resp;
        resp_val_raw = pend_q.valid;
        q_deq_rdy    = 1'b0;
        q_enq_val    = pend_q.valid & ~resp_rdy;
        // Queued responses are older than the pending one and must go first.
        if (q_deq_val) begin
            resp_sel     = q_head;
            resp_val_raw = 1'b1;
            q_deq_rdy    = resp_rdy;
            q_enq_val    = pend_q.valid;
        end
    end

    assign resp_val  = reset & resp_val_raw;
    assign resp_type = resp_sel[DATA_NBITS];
    assign resp_data = resp_sel[DATA_NBITS-1:0];

    sram_resp_queue #(
        .DEPTH (RESP_DEPTH),
        .WIDTH (RESP_NBITS)
    ) u_resp_queue (
        .clk      (clk),
        .reset    (reset),
        .enq_val  (q_enq_val),
        .enq_rdy  (unused_enq_rdy),
        .enq_data (pend_resp),
        .deq_val  (q_deq_val),
        .deq_rdy  (q_deq_rdy),
        .deq_data (q_head),
        .count    (q_count)
    );

endmodule

// File: tb/tb_sram_req_adapter.sv
// Directed bench for sram_req_adapter: pin-level SRAM model, queue-based
// response model checked every cycle, plus hand-computed literal checks.
module tb_sram_req_adapter;
    import sram_adapter_pkg::*;

    localparam int AW    = 10;
    localparam int DW    = 32;
    localparam int DEPTH = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_val, req_rdy, req_type;
    logic [AW-1:0] req_addr;
    logic [DW-1:0] req_data;
    logic          resp_val, resp_rdy, resp_type;
    logic [DW-1:0] resp_data;
    logic [AW-1:0] A1;
    logic          CE1, CSB1, WEB1, OEB1;
    logic [DW-1:0] I1, O1;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    sram_req_adapter #(
        .ADDR_NBITS (AW),
        .DATA_NBITS (DW),
        .RESP_DEPTH (DEPTH)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_val   (req_val),
        .req_rdy   (req_rdy),
        .req_type  (req_type),
        .req_addr  (req_addr),
        .req_data  (req_data),
        .resp_val  (resp_val),
        .resp_rdy  (resp_rdy),
        .resp_type (resp_type),
        .resp_data (resp_data),
        .A1        (A1),
        .CE1       (CE1),
        .CSB1      (CSB1),
        .WEB1      (WEB1),
        .OEB1      (OEB1),
        .I1        (I1),
        .O1        (O1)
    );

    function automatic logic [DW-1:0] pat(input int a);
        return 32'hA5A5_0000 + a;
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Pin-level SRAM: read data appears the cycle after the select.
    logic [DW-1:0] sram_mem [1024];
    initial begin
        for (int a = 0; a < 1024; a++) sram_mem[a] = pat(a);
        O1 = '0;
        forever begin
            @(posedge clk);
            if (!CSB1 && !WEB1) sram_mem[A1] <= I1;
            if (!CSB1 && WEB1) O1 <= sram_mem[A1];
            else O1 <= $urandom;
        end
    end

    // Reference: every accepted request owes one response, delivered in order.
    resp_t         exp_q[$];
    logic [DW-1:0] ref_mem [1024];
    logic          last_rd;
    initial begin
        logic f;
        for (int a = 0; a < 1024; a++) ref_mem[a] = pat(a);
        last_rd = 1'b0;
        forever begin
            @(posedge clk or negedge reset);
            if (!reset) begin
                exp_q.delete();
                last_rd = 1'b0;
            end else begin
                f = req_val && (exp_q.size() < DEPTH);
                if (resp_rdy && exp_q.size() > 0) void'(exp_q.pop_front());
                last_rd = f && !req_type;
                if (f) begin
                    if (req_type) begin
                        exp_q.push_back('{rtype: WRITE, data: '0});
                        ref_mem[req_addr] = req_data;
                    end else begin
                        exp_q.push_back('{rtype: READ, data: ref_mem[req_addr]});
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : cmp
        int            occ;
        logic          f;
        if (!reset) begin
            chk("rst_csb1", CSB1, 1'b1);
            chk("rst_web1", WEB1, 1'b1);
            chk("rst_oeb1", OEB1, 1'b1);
            chk("rst_req_rdy", req_rdy, 1'b0);
            chk("rst_resp_val", resp_val, 1'b0);
        end else begin
            occ = exp_q.size();
            f   = req_val && (occ < DEPTH);
            chk("req_rdy", req_rdy, occ < DEPTH);
            chk("resp_val", resp_val, occ > 0);
            if (occ > 0) begin
                chk("resp_type", resp_type, exp_q[0].rtype);
                chk("resp_data", resp_data, exp_q[0].data);
            end
            chk("ce1", CE1, 1'b1);
            chk("csb1", CSB1, !f);
            chk("web1", WEB1, f ? !req_type : 1'b1);
            chk("a1", A1, f ? req_addr : '0);
            chk("i1", I1, f ? req_data : '0);
            chk("oeb1", OEB1, !last_rd);
        end
    end

    task automatic drive(input logic v, input logic t, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic r);
        req_val  = v;
        req_type = t;
        req_addr = a;
        req_data = d;
        resp_rdy = r;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int fires;
        int resps;
        drive(0, 0, '0, '0, 0);
        repeat (3) @(posedge clk);
        #1;
        @(negedge clk);
        chk("lit_rst_req_rdy", req_rdy, 1'b0);
        chk("lit_rst_resp_val", resp_val, 1'b0);
        step();
        reset = 1'b1;
        @(negedge clk);
        chk("lit_first_req_rdy", req_rdy, 1'b1);
        step();

        // Write then read back.
        drive(1, 1, 10'h005, 32'hDEADBEEF, 1);
        @(negedge clk);
        chk("lit_wr_web1", WEB1, 1'b0);
        chk("lit_wr_csb1", CSB1, 1'b0);
        chk("lit_wr_i1", I1, 32'hDEADBEEF);
        chk("lit_wr_a1", A1, 10'h005);
        step();
        drive(1, 0, 10'h005, '0, 1);
        @(negedge clk);
        chk("lit_wr_oeb1", OEB1, 1'b1);
        chk("lit_wr_resp_val", resp_val, 1'b1);
        chk("lit_wr_resp_type", resp_type, 1'b1);
        chk("lit_wr_resp_data", resp_data, 32'h0);
        step();
        drive(0, 0, '0, '0, 1);
        @(negedge clk);
        chk("lit_rd_resp_val", resp_val, 1'b1);
        chk("lit_rd_resp_type", resp_type, 1'b0);
        chk("lit_rd_resp_data", resp_data, 32'hDEADBEEF);
        chk("lit_rd_oeb1", OEB1, 1'b0);
        step();

        // Back-to-back reads of 0x000..0x00F.
        fires = 0;
        resps = 0;
        for (int i = 0; i <= 16; i++) begin
            if (i < 16) drive(1, 0, AW'(i), '0, 1);
            else drive(0, 0, '0, '0, 1);
            @(negedge clk);
            if (i < 16 && req_rdy) fires++;
            if (resp_val) resps++;
            if (i == 4) chk("lit_burst_addr3", resp_data, 32'hA5A5_0003);
            if (i == 6) chk("lit_burst_addr5", resp_data, 32'hDEADBEEF);
            step();
        end
        chk("lit_burst_fires", fires, 16);
        chk("lit_burst_resps", resps, 16);

        // Backpressure: two reads fill the queue.
        drive(1, 0, 10'h010, '0, 0);
        @(negedge clk);
        chk("lit_bp_rdy0", req_rdy, 1'b1);
        step();
        drive(1, 0, 10'h011, '0, 0);
        @(negedge clk);
        chk("lit_bp_rdy1", req_rdy, 1'b1);
        chk("lit_bp_first", resp_data, 32'hA5A5_0010);
        step();
        drive(0, 0, '0, '0, 0);
        @(negedge clk);
        chk("lit_bp_full", req_rdy, 1'b0);
        chk("lit_bp_hold0", resp_data, 32'hA5A5_0010);
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("lit_stall_val", resp_val, 1'b1);
            chk("lit_stall_data", resp_data, 32'hA5A5_0010);
            chk("lit_stall_rdy", req_rdy, 1'b0);
            step();
        end
        drive(0, 0, '0, '0, 1);
        @(negedge clk);
        chk("lit_ack_rdy", req_rdy, 1'b0);
        chk("lit_ack_data", resp_data, 32'hA5A5_0010);
        step();
        drive(0, 0, '0, '0, 0);
        @(negedge clk);
        chk("lit_after_ack_rdy", req_rdy, 1'b1);
        chk("lit_second_data", resp_data, 32'hA5A5_0011);
        step();
        drive(0, 0, '0, '0, 1);
        @(negedge clk);
        chk("lit_second_again", resp_data, 32'hA5A5_0011);
        step();
        @(negedge clk);
        chk("lit_drained", resp_val, 1'b0);
        step();

        // Reset with one queued and one pending response.
        drive(1, 0, 10'h020, '0, 0);
        step();
        drive(1, 0, 10'h021, '0, 0);
        step();
        #1;
        reset = 1'b0;
        #1;
        chk("lit_mid_rst_csb1", CSB1, 1'b1);
        chk("lit_mid_rst_resp_val", resp_val, 1'b0);
        chk("lit_mid_rst_oeb1", OEB1, 1'b1);
        drive(0, 0, '0, '0, 1);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        @(negedge clk);
        chk("lit_post_rst_rdy", req_rdy, 1'b1);
        chk("lit_post_rst_val", resp_val, 1'b0);
        step();
        @(negedge clk);
        chk("lit_post_rst_val2", resp_val, 1'b0);
        step();

        // Mixed reads/writes with irregular response backpressure.
        for (int i = 0; i < 24; i++) begin
            drive((i % 5) != 3, (i % 3) == 0, AW'(10'h020 + (i % 4)), DW'(32'h1000 + i),
                  ((i % 4) != 1) && ((i % 7) != 2));
            step();
        end
        drive(0, 0, '0, '0, 1);
        repeat (4) step();
        @(negedge clk);
        chk("lit_final_idle", resp_val, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
